// File: rtl/toad_mover.sv
// toad_mover: steps a toad one cell at a time across a world map held in a synchronous ROM.
// Define TOAD_MOVE_COUNT_EN to build the saturating successful-move counter on move_count.
module toad_mover #(
    parameter int MIN_COORD = 2,
    parameter int MAX_COORD = 125,
    parameter int START_X   = 2,
    parameter int START_Y   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    input  logic        restart,
    input  logic [7:0]  start_x,
    input  logic [7:0]  start_y,
    output logic [13:0] map_addr,
    input  logic [1:0]  map_data,
    output logic [7:0]  locXReg,
    output logic [7:0]  locYReg,
    output logic        busy,
    output logic        moved,
    output logic        blocked,
    output logic        goal_reached,
    output logic [15:0] move_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        CHECK  = 2'd2,
        REJECT = 2'd3
    } state_t;

    localparam logic signed [8:0] MIN_S = 9'(MIN_COORD);
    localparam logic signed [8:0] MAX_S = 9'(MAX_COORD);
    localparam logic [7:0]        MIN_U = 8'(MIN_COORD);
    localparam logic [7:0]        MAX_U = 8'(MAX_COORD);

    state_t      state_q, state_d;
    logic [7:0]  loc_x_q, loc_x_d;
    logic [7:0]  loc_y_q, loc_y_d;
    logic [7:0]  tgt_x_q, tgt_x_d;
    logic [7:0]  tgt_y_q, tgt_y_d;
    logic [13:0] map_addr_q, map_addr_d;
    logic        moved_q, moved_d;
    logic        blocked_q, blocked_d;
    logic        goal_q, goal_d;

    logic signed [8:0] cand_x, cand_y;
    logic              cand_ok;
    logic              accept;
    logic              cell_open;

    function automatic logic [7:0] clamp_coord(input logic [7:0] v);
        if (v < MIN_U)
            return MIN_U;
        else if (v > MAX_U)
            return MAX_U;
        else
            return v;
    endfunction

    // Candidate target is computed one bit wider and signed so stepping off either edge cannot wrap.
    always_comb begin
        cand_x = $signed({1'b0, loc_x_q});
        cand_y = $signed({1'b0, loc_y_q});
        case (move_dir)
            2'd0:    cand_y = cand_y - 9'sd1;
            2'd1:    cand_y = cand_y + 9'sd1;
            2'd2:    cand_x = cand_x - 9'sd1;
            default: cand_x = cand_x + 9'sd1;
        endcase
        cand_ok = (cand_x >= MIN_S) && (cand_x <= MAX_S) &&
                  (cand_y >= MIN_S) && (cand_y <= MAX_S);
    end

    assign accept    = (state_q == IDLE) && move_req && !goal_q;
    // Map codes 1 and 3 are both walls, so bit 0 alone decides passability.
    assign cell_open = !map_data[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = cand_ok ? ADDR : REJECT;
                ADDR:    state_d = CHECK;
                CHECK:   state_d = IDLE;
                REJECT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath next values
    always_comb begin
        loc_x_d    = loc_x_q;
        loc_y_d    = loc_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        map_addr_d = map_addr_q;
        goal_d     = goal_q;
        moved_d    = 1'b0;
        blocked_d  = 1'b0;
        if (restart) begin
            loc_x_d = clamp_coord(start_x);
            loc_y_d = clamp_coord(start_y);
            goal_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tgt_x_d = cand_x[7:0];
                        tgt_y_d = cand_y[7:0];
                        if (cand_ok)
                            map_addr_d = {cand_y[6:0], cand_x[6:0]};
                        else
                            blocked_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (cell_open) begin
                        loc_x_d = tgt_x_q;
                        loc_y_d = tgt_y_q;
                        moved_d = 1'b1;
                        if (map_data == 2'd2)
                            goal_d = 1'b1;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loc_x_q    <= 8'(START_X);
            loc_y_q    <= 8'(START_Y);
            tgt_x_q    <= 8'd0;
            tgt_y_q    <= 8'd0;
            map_addr_q <= 14'd0;
            moved_q    <= 1'b0;
            blocked_q  <= 1'b0;
            goal_q     <= 1'b0;
        end else begin
            loc_x_q    <= loc_x_d;
            loc_y_q    <= loc_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            map_addr_q <= map_addr_d;
            moved_q    <= moved_d;
            blocked_q  <= blocked_d;
            goal_q     <= goal_d;
        end
    end

    assign map_addr     = map_addr_q;
    assign locXReg      = loc_x_q;
    assign locYReg      = loc_y_q;
    assign moved        = moved_q;
    assign blocked      = blocked_q;
    assign goal_reached = goal_q;

`ifdef TOAD_MOVE_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart)
            count_d = 16'd0;
        else if ((state_q == CHECK) && cell_open && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= 16'd0;
        else
            count_q <= count_d;
    end

    assign move_count = count_q;
`else
    assign move_count = 16'h0000;
`endif

endmodule

// File: tb/tb_toad_mover.sv
// Self-checking bench for toad_mover: directed scenarios plus randomized moves over a random map.
module tb_toad_mover;

    localparam int MIN_C = 2;
    localparam int MAX_C = 125;
`ifdef TOAD_MOVE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        move_req;
    logic [1:0]  move_dir;
    logic        restart;
    logic [7:0]  start_x, start_y;
    logic [13:0] map_addr;
    logic [1:0]  map_data;
    logic [7:0]  locXReg, locYReg;
    logic        busy, moved, blocked, goal_reached;
    logic [15:0] move_count;

    toad_mover #(.MIN_COORD(2), .MAX_COORD(125), .START_X(2), .START_Y(2)) dut (
        .clk(clk), .reset(reset), .move_req(move_req), .move_dir(move_dir),
        .restart(restart), .start_x(start_x), .start_y(start_y),
        .map_addr(map_addr), .map_data(map_data), .locXReg(locXReg), .locYReg(locYReg),
        .busy(busy), .moved(moved), .blocked(blocked), .goal_reached(goal_reached),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    // World map ROM with one cycle of read latency.
    logic [1:0] rom [0:16383];
    always @(posedge clk) map_data <= rom[map_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: where the toad is and what the last lookup address was.
    int          mx, my, mcount;
    bit          mgoal;
    logic [13:0] maddr;
    int          exp_kind;   // 0 = nothing, 1 = moved, 2 = blocked
    int          exp_cyc;
    logic [6:0]  exp_busy;

    int          obs_moved_n, obs_blocked_n, obs_moved_cyc, obs_blocked_cyc;
    bit          obs_both;
    logic [6:0]  obs_busy;
    logic [13:0] obs_addr1;

    function automatic int clampc(input int v);
        if (v < MIN_C) return MIN_C;
        if (v > MAX_C) return MAX_C;
        return v;
    endfunction

    function automatic logic [15:0] exp_count();
        return CNT_EN ? 16'(mcount) : 16'h0000;
    endfunction

    task automatic predict(input logic [1:0] dir);
        int tx, ty;
        tx = mx; ty = my;
        exp_kind = 0; exp_cyc = 0; exp_busy = '0;
        if (mgoal) return;
        case (dir)
            2'd0: ty = ty - 1;
            2'd1: ty = ty + 1;
            2'd2: tx = tx - 1;
            default: tx = tx + 1;
        endcase
        if (tx < MIN_C || tx > MAX_C || ty < MIN_C || ty > MAX_C) begin
            exp_kind = 2; exp_cyc = 1; exp_busy[1] = 1'b1;
        end else begin
            maddr = {ty[6:0], tx[6:0]};
            exp_cyc = 3; exp_busy[1] = 1'b1; exp_busy[2] = 1'b1;
            if (rom[maddr] == 2'd0 || rom[maddr] == 2'd2) begin
                exp_kind = 1;
                mx = tx; my = ty;
                if (mcount < 65535) mcount = mcount + 1;
                if (rom[maddr] == 2'd2) mgoal = 1'b1;
            end else begin
                exp_kind = 2;
            end
        end
    endtask

    // Issue one move request at the current negedge and record six cycles of response.
    task automatic run_move(input logic [1:0] dir, input int extra);
        obs_moved_n = 0; obs_blocked_n = 0; obs_moved_cyc = 0; obs_blocked_cyc = 0;
        obs_both = 1'b0; obs_busy = '0;
        move_req = 1'b1; move_dir = dir;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (moved)   begin obs_moved_n++;   obs_moved_cyc = c;   end
            if (blocked) begin obs_blocked_n++; obs_blocked_cyc = c; end
            if (moved && blocked) obs_both = 1'b1;
            obs_busy[c] = busy;
            if (c == 1) obs_addr1 = map_addr;
            move_req = (c == extra);
            move_dir = 2'($urandom);
        end
        move_req = 1'b0;
    endtask

    task automatic do_restart(input int sx, input int sy, input logic with_req);
        restart = 1'b1; start_x = 8'(sx); start_y = 8'(sy);
        move_req = with_req; move_dir = 2'($urandom);
        @(negedge clk);
        restart = 1'b0; move_req = 1'b0;
        mx = clampc(sx); my = clampc(sy); mgoal = 1'b0; mcount = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; move_req = 1'b0; move_dir = 2'd0; restart = 1'b0;
        start_x = 8'd0; start_y = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mx = 2; my = 2; mgoal = 1'b0; mcount = 0; maddr = 14'd0;
        n_cmp++; if (locXReg !== 8'd2) begin n_bad++; $display("FAIL reset_locx: got %0d want 2", locXReg); end
        n_cmp++; if (locYReg !== 8'd2) begin n_bad++; $display("FAIL reset_locy: got %0d want 2", locYReg); end
        n_cmp++; if (map_addr !== 14'd0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", map_addr); end
        n_cmp++; if ({busy, moved, blocked, goal_reached} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, moved, blocked, goal_reached}); end
        n_cmp++; if (move_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", move_count); end
        $display("txn reset: loc=(%0d,%0d)", locXReg, locYReg);
    endtask

    task automatic test_basic_move();
        rom[{7'd2, 7'd3}] = 2'd0;
        predict(2'd3);
        run_move(2'd3, 0);
        n_cmp++; if (obs_addr1 !== 14'h0103) begin n_bad++; $display("FAIL basic_addr: got %0h want 0103", obs_addr1); end
        n_cmp++; if (obs_moved_n != 1 || obs_moved_cyc != 3) begin
            n_bad++; $display("FAIL basic_moved: got n=%0d cyc=%0d want n=1 cyc=3", obs_moved_n, obs_moved_cyc); end
        n_cmp++; if (obs_blocked_n != 0) begin n_bad++; $display("FAIL basic_blocked: got %0d want 0", obs_blocked_n); end
        n_cmp++; if (locXReg !== 8'd3 || locYReg !== 8'd2) begin
            n_bad++; $display("FAIL basic_loc: got (%0d,%0d) want (3,2)", locXReg, locYReg); end
        n_cmp++; if (obs_busy !== 7'b0000110) begin n_bad++; $display("FAIL basic_busy: got %b want 0000110", obs_busy); end
        n_cmp++; if (move_count !== (CNT_EN ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL basic_count: got %0d want %0d", move_count, CNT_EN ? 1 : 0); end
        $display("txn basic_move: loc=(%0d,%0d) count=%0d", locXReg, locYReg, move_count);
    endtask

    task automatic test_out_of_range();
        do_restart(2, 2, 1'b0);
        predict(2'd0);
        run_move(2'd0, 0);
        n_cmp++; if (obs_blocked_n != 1 || obs_blocked_cyc != 1) begin
            n_bad++; $display("FAIL oor_blocked: got n=%0d cyc=%0d want n=1 cyc=1", obs_blocked_n, obs_blocked_cyc); end
        n_cmp++; if (obs_moved_n != 0) begin n_bad++; $display("FAIL oor_moved: got %0d want 0", obs_moved_n); end
        n_cmp++; if (obs_busy !== 7'b0000010) begin n_bad++; $display("FAIL oor_busy: got %b want 0000010", obs_busy); end
        n_cmp++; if (obs_addr1 !== 14'h0103) begin n_bad++; $display("FAIL oor_addr_hold: got %0h want 0103", obs_addr1); end
        n_cmp++; if (locXReg !== 8'd2 || locYReg !== 8'd2) begin
            n_bad++; $display("FAIL oor_loc: got (%0d,%0d) want (2,2)", locXReg, locYReg); end
        $display("txn out_of_range: blocked at cycle %0d", obs_blocked_cyc);
    endtask

    task automatic test_wall();
        do_restart(9, 10, 1'b0);
        rom[{7'd10, 7'd10}] = 2'd0;
        rom[{7'd10, 7'd11}] = 2'd1;
        predict(2'd3);
        run_move(2'd3, 0);
        predict(2'd3);
        run_move(2'd3, 0);
        n_cmp++; if (obs_addr1 !== 14'h050B) begin n_bad++; $display("FAIL wall_addr: got %0h want 050b", obs_addr1); end
        n_cmp++; if (obs_blocked_n != 1 || obs_blocked_cyc != 3 || obs_moved_n != 0) begin
            n_bad++; $display("FAIL wall_pulse: got blk=%0d@%0d mov=%0d want blk=1@3 mov=0",
                              obs_blocked_n, obs_blocked_cyc, obs_moved_n); end
        n_cmp++; if (locXReg !== 8'd10 || locYReg !== 8'd10) begin
            n_bad++; $display("FAIL wall_loc: got (%0d,%0d) want (10,10)", locXReg, locYReg); end
        n_cmp++; if (move_count !== (CNT_EN ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL wall_count: got %0d want %0d", move_count, CNT_EN ? 1 : 0); end
        $display("txn wall: blocked at cycle %0d loc=(%0d,%0d)", obs_blocked_cyc, locXReg, locYReg);
    endtask

    task automatic test_goal();
        do_restart(20, 20, 1'b0);
        rom[{7'd21, 7'd20}] = 2'd2;
        predict(2'd1);
        run_move(2'd1, 0);
        n_cmp++; if (locYReg !== 8'd21 || obs_moved_n != 1 || obs_moved_cyc != 3) begin
            n_bad++; $display("FAIL goal_move: got y=%0d mov=%0d@%0d want y=21 mov=1@3", locYReg, obs_moved_n, obs_moved_cyc); end
        n_cmp++; if (goal_reached !== 1'b1) begin n_bad++; $display("FAIL goal_flag: got %b want 1", goal_reached); end
        predict(2'd2);
        run_move(2'd2, 1);
        n_cmp++; if (obs_busy !== 7'b0 || obs_moved_n != 0 || obs_blocked_n != 0) begin
            n_bad++; $display("FAIL goal_ignore: got busy=%b mov=%0d blk=%0d want 0", obs_busy, obs_moved_n, obs_blocked_n); end
        n_cmp++; if (locXReg !== 8'd20 || locYReg !== 8'd21 || goal_reached !== 1'b1) begin
            n_bad++; $display("FAIL goal_hold: got (%0d,%0d) g=%b want (20,21) g=1", locXReg, locYReg, goal_reached); end
        do_restart(60, 60, 1'b0);
        n_cmp++; if (goal_reached !== 1'b0) begin n_bad++; $display("FAIL goal_clear: got %b want 0", goal_reached); end
        $display("txn goal: goal reached then cleared by restart");
    endtask

    task automatic test_busy_ignore();
        do_restart(40, 40, 1'b0);
        rom[{7'd40, 7'd41}] = 2'd0;
        predict(2'd3);
        run_move(2'd3, 2);
        n_cmp++; if (obs_moved_n + obs_blocked_n != 1) begin
            n_bad++; $display("FAIL busy_pulses: got %0d want 1", obs_moved_n + obs_blocked_n); end
        n_cmp++; if (obs_busy !== 7'b0000110) begin n_bad++; $display("FAIL busy_mask: got %b want 0000110", obs_busy); end
        n_cmp++; if (locXReg !== 8'd41) begin n_bad++; $display("FAIL busy_loc: got %0d want 41", locXReg); end
        do_restart(200, 0, 1'b0);
        @(negedge clk);
        n_cmp++; if (locXReg !== 8'd125 || locYReg !== 8'd2) begin
            n_bad++; $display("FAIL clamp_loc: got (%0d,%0d) want (125,2)", locXReg, locYReg); end
        n_cmp++; if (goal_reached !== 1'b0 || move_count !== 16'd0) begin
            n_bad++; $display("FAIL clamp_state: got g=%b cnt=%0d want 0/0", goal_reached, move_count); end
        $display("txn busy_ignore: pulses=%0d then restart to (%0d,%0d)", obs_moved_n + obs_blocked_n, locXReg, locYReg);
    endtask

    task automatic test_restart_priority();
        int pulses, busy_seen;
        rom[{7'd50, 7'd51}] = 2'd0;
        do_restart(50, 50, 1'b1);
        pulses = 0; busy_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (moved || blocked) pulses++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_cmp++; if (pulses != 0 || busy_seen != 0 || locXReg !== 8'd50) begin
            n_bad++; $display("FAIL restart_with_req: got pulses=%0d busy=%0d x=%0d want 0/0/50", pulses, busy_seen, locXReg); end
        // Restart landing while the lookup is in ADDR discards it.
        move_req = 1'b1; move_dir = 2'd3;
        @(negedge clk);
        move_req = 1'b0;
        do_restart(30, 30, 1'b0);
        pulses = 0; busy_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (moved || blocked) pulses++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_cmp++; if (pulses != 0 || busy_seen != 0) begin
            n_bad++; $display("FAIL restart_abort: got pulses=%0d busy=%0d want 0/0", pulses, busy_seen); end
        n_cmp++; if (locXReg !== 8'd30 || locYReg !== 8'd30) begin
            n_bad++; $display("FAIL restart_abort_loc: got (%0d,%0d) want (30,30)", locXReg, locYReg); end
        $display("txn restart_priority: loc=(%0d,%0d)", locXReg, locYReg);
    endtask

    task automatic test_reset_midmove();
        int pulses;
        do_restart(70, 70, 1'b0);
        rom[{7'd70, 7'd71}] = 2'd0;
        move_req = 1'b1; move_dir = 2'd3;
        @(negedge clk);
        move_req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_inflight: got busy=%b want 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (locXReg !== 8'd2 || locYReg !== 8'd2 || map_addr !== 14'd0) begin
            n_bad++; $display("FAIL midreset_async: got (%0d,%0d) addr=%0h want (2,2) 0", locXReg, locYReg, map_addr); end
        n_cmp++; if ({busy, moved, blocked, goal_reached} !== 4'b0 || move_count !== 16'd0) begin
            n_bad++; $display("FAIL midreset_flags: got %b cnt=%0d want 0", {busy, moved, blocked, goal_reached}, move_count); end
        @(negedge clk);
        reset = 1'b0;
        mx = 2; my = 2; mgoal = 1'b0; mcount = 0; maddr = 14'd0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (moved || blocked || busy) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midreset_nopulse: got %0d want 0", pulses); end
        // Move issued right at reset release must be taken on the first edge.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rom[{7'd2, 7'd3}] = 2'd0;
        predict(2'd3);
        run_move(2'd3, 0);
        n_cmp++; if (obs_moved_n != 1 || obs_moved_cyc != 3 || locXReg !== 8'd3) begin
            n_bad++; $display("FAIL first_edge_move: got mov=%0d@%0d x=%0d want 1@3 x=3", obs_moved_n, obs_moved_cyc, locXReg); end
        $display("txn reset_midmove: loc=(%0d,%0d)", locXReg, locYReg);
    endtask

    task automatic test_random();
        int sx, sy, extra, e_mn, e_mc, e_bn, e_bc;
        logic [1:0] dir;
        for (int it = 0; it < 200; it++) begin
            if (mgoal || $urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    sx = $urandom_range(0, 255); sy = $urandom_range(0, 255);
                end else begin
                    sx = MIN_C + $urandom_range(0, 1); sy = MAX_C - $urandom_range(0, 1);
                    if ($urandom_range(0, 1) == 0) begin sx = MAX_C; sy = MIN_C; end
                end
                do_restart(sx, sy, 1'($urandom_range(0, 1)));
            end
            dir = 2'($urandom_range(0, 3));
            predict(dir);
            if (exp_kind == 0)      extra = 0;
            else if (exp_cyc == 1)  extra = $urandom_range(0, 1);
            else                    extra = $urandom_range(0, 2);
            run_move(dir, extra);
            e_mn = (exp_kind == 1) ? 1 : 0; e_mc = (exp_kind == 1) ? exp_cyc : 0;
            e_bn = (exp_kind == 2) ? 1 : 0; e_bc = (exp_kind == 2) ? exp_cyc : 0;
            n_cmp++; if (obs_moved_n != e_mn || obs_moved_cyc != e_mc) begin
                n_bad++; $display("FAIL rnd_moved[%0d]: got %0d@%0d want %0d@%0d", it, obs_moved_n, obs_moved_cyc, e_mn, e_mc); end
            n_cmp++; if (obs_blocked_n != e_bn || obs_blocked_cyc != e_bc) begin
                n_bad++; $display("FAIL rnd_blocked[%0d]: got %0d@%0d want %0d@%0d", it, obs_blocked_n, obs_blocked_cyc, e_bn, e_bc); end
            n_cmp++; if (obs_both) begin n_bad++; $display("FAIL rnd_both[%0d]: got 1 want 0", it); end
            n_cmp++; if (obs_busy !== exp_busy) begin
                n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", it, obs_busy, exp_busy); end
            n_cmp++; if (obs_addr1 !== maddr) begin
                n_bad++; $display("FAIL rnd_addr[%0d]: got %0h want %0h", it, obs_addr1, maddr); end
            n_cmp++; if (locXReg !== 8'(mx) || locYReg !== 8'(my)) begin
                n_bad++; $display("FAIL rnd_loc[%0d]: got (%0d,%0d) want (%0d,%0d)", it, locXReg, locYReg, mx, my); end
            n_cmp++; if (goal_reached !== mgoal || move_count !== exp_count()) begin
                n_bad++; $display("FAIL rnd_state[%0d]: got g=%b cnt=%0d want g=%b cnt=%0d",
                                  it, goal_reached, move_count, mgoal, exp_count()); end
            $display("txn rnd %0d: dir=%0d kind=%0d loc=(%0d,%0d) cnt=%0d", it, dir, exp_kind, locXReg, locYReg, move_count);
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 16384; i++) begin
            r = $urandom_range(0, 99);
            rom[i] = (r < 60) ? 2'd0 : (r < 62) ? 2'd2 : (r < 81) ? 2'd1 : 2'd3;
        end
        test_reset();
        test_basic_move();
        test_out_of_range();
        test_wall();
        test_goal();
        test_busy_ignore();
        test_restart_priority();
        test_reset_midmove();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/toad_mover.md
TOAD_MOVER -- requirements
Module: toad_mover

Interface
REQ-001 The block SHALL have the parameter MIN_COORD, default 2, which is the lowest legal toad cell coordinate (icon fully on screen).
REQ-002 The block SHALL have the parameter MAX_COORD, default 125, which is the highest legal toad cell coordinate.
REQ-003 The block SHALL have the parameter START_X, default 2, which is the reset X cell.
REQ-004 The block SHALL have the parameter START_Y, default 2, which is the reset Y cell.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single system clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port move_req, input, 1 bit: one-cycle move request.
REQ-008 The block SHALL have the port move_dir, input, 2 bits: 0=up (Y-1), 1=down (Y+1), 2=left (X-1), 3=right (X+1); sampled with move_req.
REQ-009 The block SHALL have the port restart, input, 1 bit: synchronous reload of the start position.
REQ-010 The block SHALL have the port start_x / start_y, input, 8 bits each: restart position.
REQ-011 The block SHALL have the port map_addr, output, 14 bits: world-map read address {y[6:0], x[6:0]}.
REQ-012 The block SHALL have the port map_data, input, 2 bits: world-map cell, valid one cycle after map_addr (synchronous ROM); 0=floor, 1=wall, 2=goal, 3=wall.
REQ-013 The block SHALL have the port locXReg / locYReg, output, 8 bits each: current toad cell, registered; feeds the icon renderer.
REQ-014 The block SHALL have the port busy, output, 1 bit: high while a move is in flight.
REQ-015 The block SHALL have the port moved / blocked, output, 1 bit each: one-cycle result pulses.
REQ-016 The block SHALL have the port goal_reached, output, 1 bit: sticky flag.
REQ-017 The block SHALL have the port move_count, output, 16 bits: number of successful moves.

Function
REQ-018 The FSM SHALL have the states IDLE, ADDR, CHECK and REJECT; busy SHALL be 1 in every state except IDLE.
REQ-019 In IDLE, when move_req=1 with goal_reached=0 at edge N, the target SHALL be registered as the current position with the move_dir offset applied; the target arithmetic SHALL be 9-bit signed with no wrap.
REQ-020 If the target is less than MIN_COORD or greater than MAX_COORD on either axis, the FSM SHALL go to REJECT; blocked SHALL be 1 in cycle N+1; the position SHALL be unchanged; no map read SHALL occur; the FSM SHALL return to IDLE at N+2.
REQ-021 If the target is in range, the FSM SHALL go to ADDR with map_addr = {target_y[6:0], target_x[6:0]} registered; at N+2 it SHALL go to CHECK, where map_data is sampled.
REQ-022 When CHECK is left at N+3 with map_data of 0 or 2, the position SHALL become the target, moved SHALL be 1 during cycle N+3, and move_count SHALL be incremented.
REQ-023 If map_data was 2 in that case, goal_reached SHALL be set during cycle N+3.
REQ-024 When CHECK is left at N+3 with map_data of 1 or 3, the position SHALL be unchanged and blocked SHALL be 1 during cycle N+3.
REQ-025 move_req SHALL be ignored (not queued) while busy=1 or goal_reached=1.
REQ-026 moved and blocked SHALL never both be high, and each SHALL be exactly one cycle wide.
REQ-027 move_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-028 restart SHALL have the highest priority in any state: next cycle state=IDLE, the position = start_x/start_y clamped to [MIN_COORD, MAX_COORD], goal_reached=0, move_count=0, moved=blocked=0, and any in-flight lookup SHALL be discarded.
REQ-029 When restart and move_req are high in the same cycle, the restart SHALL win and the move SHALL be dropped.
REQ-030 map_addr SHALL hold its last value outside ADDR.

Reset
REQ-031 On reset=1, independent of clk: state=IDLE, locXReg=START_X, locYReg=START_Y, map_addr=0, busy=0, moved=0, blocked=0, goal_reached=0, move_count=0.
REQ-032 Reset asserted mid-move SHALL abort the move with no result pulse after release.
REQ-033 The first move SHALL be accepted on the first edge with reset low.

Configuration
REQ-034 The block SHALL be configured by the macro TOAD_MOVE_COUNT_EN.
REQ-035 With TOAD_MOVE_COUNT_EN defined, the move_count counter SHALL be implemented per REQ-022, REQ-027 and REQ-028.
REQ-036 Without TOAD_MOVE_COUNT_EN, no counter register SHALL be built and move_count SHALL be tied to 16'h0000; all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then move_req dir=3 onto a floor cell at (3,2) -> map_addr=14'h0103 in ADDR; locXReg=3 at N+3; moved is a one-cycle pulse; move_count=1.
REQ-038 Toad at (2,2), move_req dir=0 -> target Y=1 out of range: blocked at N+1, no ADDR state, position stays (2,2).
REQ-039 Wall (map_data=1) to the right of (10,10), dir=3 -> blocked at N+3, position stays (10,10), move_count unchanged.
REQ-040 Goal (map_data=2) below (20,20), dir=1 -> locYReg=21, moved=1, goal_reached=1; a further move_req produces no busy, no pulses and no change.
REQ-041 move_req pulsed during CHECK -> ignored; exactly one result pulse occurs; restart with start_x=200, start_y=0 -> position (125,2), goal_reached=0, move_count=0.
REQ-042 reset asserted during ADDR -> outputs take reset values immediately; with TOAD_MOVE_COUNT_EN undefined, move_count reads 0 after 3 successful moves.
